// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel prescaler, x/y raster counters and registered
// sync/blank outputs aligned with the counters they describe.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt) that increments each time the raster wraps to (0,0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          HS,
    output logic          VS,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          blank,
    output logic          pix_en,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    // Sync/blank window edges kept 32 bits wide so an edge equal to 2^CW still compares correctly
    localparam logic [31:0] HS_START = H_ACTIVE + H_FP;
    localparam logic [31:0] HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0] VS_START = V_ACTIVE + V_FP;
    localparam logic [31:0] VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [31:0] H_VIS    = H_ACTIVE;
    localparam logic [31:0] V_VIS    = V_ACTIVE;

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          hs_next;
    logic          vs_next;
    logic          blank_next;
    logic          frame_wrap;

    // Strobes are combinational so they line up with the edge that advances the counters
    assign pix_en      = en && !reset && (pre == PRE_LAST);
    assign line_start  = pix_en && (x == '0);
    assign frame_start = line_start && (y == '0);
    assign frame_wrap  = pix_en && (x == H_LAST) && (y == V_LAST);

    // Next raster position and the sync/blank levels that belong to it
    always_comb begin
        pre_next = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        x_next   = x;
        y_next   = y;
        if (pix_en) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + CW'(1);
            end else begin
                x_next = x + CW'(1);
            end
        end
        hs_next    = ((32'(x_next) >= HS_START) && (32'(x_next) < HS_END)) ? HS_POL : ~HS_POL;
        vs_next    = ((32'(y_next) >= VS_START) && (32'(y_next) < VS_END)) ? VS_POL : ~VS_POL;
        blank_next = (32'(x_next) >= H_VIS) || (32'(y_next) >= V_VIS);
    end

    // Timing state; everything freezes while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            x     <= '0;
            y     <= '0;
            HS    <= ~HS_POL;
            VS    <= ~VS_POL;
            blank <= 1'b0;
        end else if (en) begin
            pre   <= pre_next;
            x     <= x_next;
            y     <= y_next;
            HS    <= hs_next;
            VS    <= vs_next;
            blank <= blank_next;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter bumps on the edge where the raster returns to (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
